// File: rtl/link_wb_arbiter.sv
// link_wb_arbiter
//
// Shares the register file's single write port between the pipeline
// writeback stage and branch-with-link (BL) link writes (X30 <= PC+4).
// Link requests wait in a small FIFO and drain into write-port slots that
// writeback leaves idle. Writeback always has priority and is never stalled.
// A writeback to X30 discards every queued link entry, because those entries
// are older and would otherwise overwrite the newer writeback value. The
// newest queued link value is exposed so that read ports can bypass it.
//
// Handshake: a link request is accepted at a rising edge when link_valid and
// link_ready are both 1. link_ready depends only on reset_n and the current
// occupancy, so a pop in the same cycle gives no credit. A request that is
// not accepted is dropped, and upstream must hold it until it is accepted.
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   reset_n          synchronous active-low reset
//   wb_en            writeback requests a register write this cycle
//   wb_reg           writeback destination register
//   wb_data          writeback data
//   link_valid       BL link write request
//   link_pc_plus4    link value (PC+4) destined for X30
//   link_ready       FIFO can accept a link request this cycle
//   rf_we            registered register-file write enable
//   rf_reg           registered register-file write address
//   rf_data          registered register-file write data
//   x30_pending      at least one link write is queued
//   x30_pending_data data of the newest queued link entry
//   fifo_count       number of queued link entries
module link_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wb_en,
    input  logic [4:0]       wb_reg,
    input  logic [63:0]      wb_data,
    input  logic             link_valid,
    input  logic [63:0]      link_pc_plus4,
    output logic             link_ready,
    output logic             rf_we,
    output logic [4:0]       rf_reg,
    output logic [63:0]      rf_data,
    output logic             x30_pending,
    output logic [63:0]      x30_pending_data,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [63:0]      fifo_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] newest_idx;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_reg_q, rf_reg_d;
    logic [63:0]      rf_data_q, rf_data_d;
    logic [63:0]      pend_hold_q;

    logic push;
    logic pop;
    logic wb_write;
    logic flush;

    assign link_ready = reset_n && (count_q < FULL_CNT);
    assign newest_idx = wptr_q - PTR_W'(1);

    always_comb begin
        push     = link_valid && link_ready;
        // X31 is the zero register, so a writeback to it leaves the slot idle.
        wb_write = wb_en && (wb_reg != 5'd31);
        flush    = wb_write && (wb_reg == 5'd30);
        pop      = !wb_write && (count_q != '0);

        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        wr_idx    = wptr_q;
        rf_we_d   = 1'b0;
        rf_reg_d  = rf_reg_q;
        rf_data_d = rf_data_q;

        if (wb_write) begin
            rf_we_d   = 1'b1;
            rf_reg_d  = wb_reg;
            rf_data_d = wb_data;
        end else if (pop) begin
            rf_we_d   = 1'b1;
            rf_reg_d  = 5'd30;
            rf_data_d = fifo_q[rptr_q];
        end

        if (flush) begin
            // Queued entries are older than this X30 writeback and are dropped.
            // A link accepted in the same cycle is younger and restarts the
            // queue at slot 0.
            rptr_d  = '0;
            wr_idx  = '0;
            wptr_d  = push ? PTR_W'(1) : '0;
            count_d = push ? CNT_W'(1) : '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push && pop) count_d = count_q - CNT_W'(1);
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_idx] <= link_pc_plus4;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rf_we_q     <= 1'b0;
            rf_reg_q    <= '0;
            rf_data_q   <= '0;
            pend_hold_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rf_we_q     <= rf_we_d;
            rf_reg_q    <= rf_reg_d;
            rf_data_q   <= rf_data_d;
            pend_hold_q <= x30_pending_data;
        end
    end

    assign rf_we            = rf_we_q;
    assign rf_reg           = rf_reg_q;
    assign rf_data          = rf_data_q;
    assign fifo_count       = count_q;
    assign x30_pending      = (count_q != '0);
    // When nothing is queued, the last exposed value is held.
    assign x30_pending_data = x30_pending ? fifo_q[newest_idx] : pend_hold_q;

endmodule

// File: tb/tb_link_wb_arbiter.sv
module tb_link_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n = 1'b0;
  logic             wb_en = 1'b0;
  logic [4:0]       wb_reg = '0;
  logic [63:0]      wb_data = '0;
  logic             link_valid = 1'b0;
  logic [63:0]      link_pc_plus4 = '0;
  logic             link_ready;
  logic             rf_we;
  logic [4:0]       rf_reg;
  logic [63:0]      rf_data;
  logic             x30_pending;
  logic [63:0]      x30_pending_data;
  logic [CNT_W-1:0] fifo_count;

  link_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .wb_en(wb_en),
    .wb_reg(wb_reg),
    .wb_data(wb_data),
    .link_valid(link_valid),
    .link_pc_plus4(link_pc_plus4),
    .link_ready(link_ready),
    .rf_we(rf_we),
    .rf_reg(rf_reg),
    .rf_data(rf_data),
    .x30_pending(x30_pending),
    .x30_pending_data(x30_pending_data),
    .fifo_count(fifo_count)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: queue of pending link values plus the write-port register
  logic [63:0] exp_q[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_reg = '0;
  logic [63:0] m_data = '0;

  always @(posedge clk) begin
    bit accept;
    if (!reset_n) begin
      exp_q.delete();
      m_we = 1'b0;
      m_reg = '0;
      m_data = '0;
    end else begin
      accept = link_valid && (exp_q.size() < DEPTH);
      if (wb_en && wb_reg != 5'd31) begin
        m_we = 1'b1;
        m_reg = wb_reg;
        m_data = wb_data;
        if (wb_reg == 5'd30) exp_q.delete();
      end else if (exp_q.size() > 0) begin
        m_we = 1'b1;
        m_reg = 5'd30;
        m_data = exp_q.pop_front();
      end else begin
        m_we = 1'b0;
      end
      if (accept) exp_q.push_back(link_pc_plus4);
    end
  end

  // scoreboard compare, every cycle, one time unit after the falling edge
  always @(negedge clk) begin
    #1;
    chk("link_ready", 64'(link_ready), 64'(reset_n && (exp_q.size() < DEPTH)));
    chk("rf_we", 64'(rf_we), 64'(m_we));
    chk("rf_reg", 64'(rf_reg), 64'(m_reg));
    chk("rf_data", rf_data, m_data);
    chk("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
    chk("x30_pending", 64'(x30_pending), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("x30_pending_data", x30_pending_data, exp_q[$]);
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    wb_en = 1'b0;
    wb_reg = '0;
    wb_data = '0;
    link_valid = 1'b0;
    link_pc_plus4 = '0;
  endtask

  logic [63:0] vals [5];

  initial begin
    vals[0] = 64'h10; vals[1] = 64'h20; vals[2] = 64'h30; vals[3] = 64'h40; vals[4] = 64'h50;

    // reset state
    tick(); tick();
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_reg", 64'(rf_reg), 64'd0);
    chk("rst_data", rf_data, 64'd0);
    chk("rst_ready", 64'(link_ready), 64'd0);
    reset_n = 1'b1;

    // 1: idle slot drain
    link_valid = 1'b1; link_pc_plus4 = 64'h1004;
    tick();
    link_valid = 1'b0;
    chk("t1_count", 64'(fifo_count), 64'd1);
    chk("t1_pdata", x30_pending_data, 64'h1004);
    chk("t1_we0", 64'(rf_we), 64'd0);
    tick();
    chk("t1_we", 64'(rf_we), 64'd1);
    chk("t1_reg", 64'(rf_reg), 64'd30);
    chk("t1_data", rf_data, 64'h1004);
    chk("t1_pend", 64'(x30_pending), 64'd0);
    tick();
    chk("t1_idle", 64'(rf_we), 64'd0);

    // 2: writeback priority
    link_valid = 1'b1; link_pc_plus4 = 64'h2008;
    tick();
    link_valid = 1'b0;
    wb_en = 1'b1; wb_reg = 5'd5; wb_data = 64'hAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_reg", 64'(rf_reg), 64'd5);
      chk("t2_data", rf_data, 64'hAA);
      chk("t2_count", 64'(fifo_count), 64'd1);
    end
    wb_en = 1'b0;
    tick();
    chk("t2_lreg", 64'(rf_reg), 64'd30);
    chk("t2_ldata", rf_data, 64'h2008);

    // 3: full / backpressure / pointer wrap
    tick();
    wb_en = 1'b1; wb_reg = 5'd1; wb_data = 64'h11;
    link_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      link_pc_plus4 = vals[i];
      chk("t3_ready", 64'(link_ready), 64'd1);
      tick();
    end
    link_pc_plus4 = vals[4];
    chk("t3_full", 64'(link_ready), 64'd0);
    tick();
    chk("t3_hold", 64'(fifo_count), 64'd4);
    wb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) link_valid = 1'b0;
      chk("t3_drain", rf_data, vals[i]);
      chk("t3_dreg", 64'(rf_reg), 64'd30);
    end
    chk("t3_wrap_pdata", x30_pending_data, 64'h50);
    tick();
    chk("t3_last", rf_data, 64'h50);
    chk("t3_empty", 64'(fifo_count), 64'd0);

    // 4: flush on writeback to X30
    wb_en = 1'b1; wb_reg = 5'd2; wb_data = 64'h22;
    link_valid = 1'b1; link_pc_plus4 = 64'h100;
    tick();
    link_pc_plus4 = 64'h104;
    tick();
    wb_reg = 5'd30; wb_data = 64'hBEEF; link_pc_plus4 = 64'h108;
    tick();
    wb_en = 1'b0; link_valid = 1'b0;
    chk("t4_reg", 64'(rf_reg), 64'd30);
    chk("t4_data", rf_data, 64'hBEEF);
    chk("t4_count", 64'(fifo_count), 64'd1);
    tick();
    chk("t4_drain", rf_data, 64'h108);
    tick();
    chk("t4_idle", 64'(rf_we), 64'd0);

    // 5: XZR writeback leaves the slot to the link
    wb_en = 1'b1; wb_reg = 5'd31; wb_data = 64'hDEAD;
    link_valid = 1'b1; link_pc_plus4 = 64'h300;
    tick();
    link_valid = 1'b0;
    tick();
    chk("t5_we", 64'(rf_we), 64'd1);
    chk("t5_reg", 64'(rf_reg), 64'd30);
    chk("t5_data", rf_data, 64'h300);
    tick();
    chk("t5_noxzr", 64'(rf_we), 64'd0);
    wb_en = 1'b0;

    // 6: reset mid-operation
    wb_en = 1'b1; wb_reg = 5'd2; wb_data = 64'h22;
    link_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      link_pc_plus4 = 64'h400 + 64'(4 * i);
      tick();
    end
    idle_inputs();
    chk("t6_pre", 64'(fifo_count), 64'd3);
    reset_n = 1'b0;
    #1;
    chk("t6_ready_rst", 64'(link_ready), 64'd0);
    tick();
    chk("t6_we", 64'(rf_we), 64'd0);
    chk("t6_count", 64'(fifo_count), 64'd0);
    chk("t6_ready", 64'(link_ready), 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_nowrite", 64'(rf_we), 64'd0);
    end

    // randomized phase, checked every cycle by the scoreboard
    for (int n = 0; n < 3000; n++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      wb_en = ($urandom_range(0, 99) < 45);
      case ($urandom_range(0, 3))
        0: wb_reg = 5'd30;
        1: wb_reg = 5'd31;
        default: wb_reg = 5'($urandom_range(0, 31));
      endcase
      wb_data = {32'($urandom), 32'($urandom)};
      link_valid = ($urandom_range(0, 99) < 60);
      link_pc_plus4 = {32'($urandom), 32'($urandom)};
      tick();
    end

    idle_inputs();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
